// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle: stall/flush requests from ID/EX toward the control unit,
// and the per-register stall vector, done pulse and perf count back to the pipeline.
interface pipe_ctrl_if #(
  parameter int CNT_W  = 6,
  parameter int PERF_W = 32
);
  logic              stallreq_id;
  logic              ex_mc_start;
  logic [CNT_W-1:0]  ex_mc_cycles;
  logic              flush_req;
  logic [5:0]        ctrl_signal;
  logic              ex_mc_done;
  logic              mc_busy;
  logic              flush;
  logic [PERF_W-1:0] stall_cycles;

  modport master (
    output stallreq_id, ex_mc_start, ex_mc_cycles, flush_req,
    input  ctrl_signal, ex_mc_done, mc_busy, flush, stall_cycles
  );

  modport slave (
    input  stallreq_id, ex_mc_start, ex_mc_cycles, flush_req,
    output ctrl_signal, ex_mc_done, mc_busy, flush, stall_cycles
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush control: stall vector is combinational in the request cycle; a
// multi-cycle EX op of N cycles stalls N cycles and pulses done in cycle N; flush overrides all.
module pipe_ctrl #(
  parameter int CNT_W  = 6,
  parameter int PERF_W = 32
) (
  input  logic      clk,
  input  logic      rst,
  pipe_ctrl_if.slave pif
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [CNT_W-1:0]  n_eff;
  logic [PERF_W-1:0] perf_q;
  logic              ex_stall;
  logic [5:0]        ctrl;
  logic              done;

  // A zero length is treated as a single-cycle op.
  assign n_eff    = (pif.ex_mc_cycles == '0) ? CNT_W'(1) : pif.ex_mc_cycles;
  assign ex_stall = ((state == IDLE) && pif.ex_mc_start) || (state == BUSY);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ctrl      = 6'b000000;
    done      = 1'b0;
    if (pif.flush_req) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (pif.ex_mc_start) begin
            if (n_eff == CNT_W'(1)) begin
              state_nxt = DONE;
              cnt_nxt   = '0;
            end else begin
              state_nxt = BUSY;
              cnt_nxt   = n_eff - CNT_W'(1);
            end
          end
        end
        BUSY: begin
          cnt_nxt = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state_nxt = DONE;
        end
        DONE: begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
      // EX stall also holds ID/EX, so it wins over a load-use request.
      if (ex_stall)             ctrl = 6'b001111;
      else if (pif.stallreq_id) ctrl = 6'b000111;
    end
    // Outputs are quiet while reset is held, even though inputs may be active.
    if (!rst) begin
      ctrl = 6'b000000;
      done = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      perf_q <= '0;
    else if (ctrl[0] && (perf_q != '1))
      perf_q <= perf_q + PERF_W'(1);
  end

  assign pif.ctrl_signal  = ctrl;
  assign pif.ex_mc_done   = done;
  assign pif.mc_busy      = rst && (state == BUSY);
  assign pif.flush        = rst && pif.flush_req;
  assign pif.stall_cycles = perf_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scenarios plus random traffic against a timestamp-based model of the
// stall/done timing, on a 32-bit and a 4-bit (saturating) perf-counter instance.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(6), .PERF_W(32)) ifb ();
  pipe_ctrl_if #(.CNT_W(6), .PERF_W(4))  ifs ();

  pipe_ctrl #(.CNT_W(6), .PERF_W(32)) dut   (.clk(clk), .rst(rst), .pif(ifb));
  pipe_ctrl #(.CNT_W(6), .PERF_W(4))  dut_s (.clk(clk), .rst(rst), .pif(ifs));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_in(input bit id, input bit st, input int cyc, input bit fl);
    ifb.stallreq_id  = id;  ifs.stallreq_id  = id;
    ifb.ex_mc_start  = st;  ifs.ex_mc_start  = st;
    ifb.ex_mc_cycles = 6'(cyc); ifs.ex_mc_cycles = 6'(cyc);
    ifb.flush_req    = fl;  ifs.flush_req    = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: an op started at cycle t0 with length n stalls cycles t0..t0+n-1 and
  // reports done at t0+n; busy covers t0+1..t0+n-1.
  int          cyc_no = 0;
  bit          op_act = 0;
  int          t0 = 0;
  int          n  = 0;
  int          d;
  logic [31:0] m_cnt  = 0;
  int          m_cnt4 = 0;
  logic [5:0]  e_ctrl;
  bit          e_done, e_busy, e_fl, ex;

  always @(negedge clk) begin
    cyc_no++;
    e_ctrl = 6'h00; e_done = 0; e_busy = 0; e_fl = 0; ex = 0;
    if (!rst) begin
      op_act = 0;
      m_cnt  = 0;
      m_cnt4 = 0;
    end else begin
      e_fl = ifb.flush_req;
      d    = op_act ? (cyc_no - t0) : 0;
      if (ifb.flush_req) begin
        e_busy = op_act && (d < n);
        op_act = 0;
      end else if (!op_act) begin
        ex = ifb.ex_mc_start;
        if (ifb.ex_mc_start) begin
          op_act = 1;
          t0     = cyc_no;
          n      = (ifb.ex_mc_cycles == 0) ? 1 : int'(ifb.ex_mc_cycles);
        end
      end else begin
        ex     = (d < n);
        e_busy = (d < n);
        e_done = (d == n);
        if (d == n) op_act = 0;
      end
      if (e_fl)                 e_ctrl = 6'h00;
      else if (ex)              e_ctrl = 6'h0F;
      else if (ifb.stallreq_id) e_ctrl = 6'h07;
    end
    chk("ctrl",      32'(ifb.ctrl_signal),  32'(e_ctrl));
    chk("done",      32'(ifb.ex_mc_done),   32'(e_done));
    chk("busy",      32'(ifb.mc_busy),      32'(e_busy));
    chk("flush",     32'(ifb.flush),        32'(e_fl));
    chk("stall_cnt", ifb.stall_cycles,      m_cnt);
    chk("ctrl_s",    32'(ifs.ctrl_signal),  32'(e_ctrl));
    chk("stall_s",   32'(ifs.stall_cycles), 32'(m_cnt4));
    if (rst && e_ctrl[0]) begin
      m_cnt  = m_cnt + 1;
      m_cnt4 = (m_cnt4 == 15) ? 15 : m_cnt4 + 1;
    end
  end

  initial begin
    set_in(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_ctrl",  32'(ifb.ctrl_signal), 32'h0);
    chk("rst_stall", ifb.stall_cycles,     32'd0);
    repeat (3) step();
    chk("idle_stall", ifb.stall_cycles, 32'd0);

    // load-use: one cycle
    step(); set_in(1, 0, 0, 0); #1;
    chk("id_ctrl", 32'(ifb.ctrl_signal), 32'h07);
    step(); set_in(0, 0, 0, 0); #1;
    chk("id_after", 32'(ifb.ctrl_signal), 32'h00);
    chk("id_cnt",   ifb.stall_cycles,     32'd1);

    // divide, N=34
    step(); set_in(0, 1, 34, 0); #1;
    chk("div_ctrl", 32'(ifb.ctrl_signal), 32'h0F);
    chk("div_busy0", 32'(ifb.mc_busy),    32'h0);
    repeat (33) step();
    step(); set_in(0, 0, 0, 0); #1;
    chk("div_done", 32'(ifb.ex_mc_done), 32'h1);
    chk("div_cnt",  ifb.stall_cycles,    32'd35);

    // N=0 and N=1 both take one stall cycle
    step(); set_in(0, 1, 0, 0); #1;
    chk("n0_ctrl", 32'(ifb.ctrl_signal), 32'h0F);
    step(); set_in(0, 0, 0, 0); #1;
    chk("n0_done", 32'(ifb.ex_mc_done), 32'h1);
    chk("n0_cnt",  ifb.stall_cycles,    32'd36);
    step(); set_in(0, 1, 1, 0); #1;
    step(); set_in(0, 0, 0, 0); #1;
    chk("n1_done", 32'(ifb.ex_mc_done), 32'h1);
    chk("n1_cnt",  ifb.stall_cycles,    32'd37);

    // ID request overlapping a busy op and the done cycle
    step(); set_in(0, 1, 5, 0);
    step();
    step(); set_in(1, 1, 5, 0); #1;
    chk("ovl_ctrl", 32'(ifb.ctrl_signal), 32'h0F);
    step();
    step();
    step(); #1;
    chk("ovl_done_ctrl", 32'(ifb.ctrl_signal), 32'h07);
    chk("ovl_done",      32'(ifb.ex_mc_done),  32'h1);
    chk("ovl_cnt",       ifb.stall_cycles,     32'd42);
    step(); set_in(0, 0, 0, 0); #1;
    chk("ovl_cnt2", ifb.stall_cycles, 32'd43);

    // flush at T+4 of an N=10 op, restart with N=3 at T+5
    step(); set_in(0, 1, 10, 0);
    repeat (3) step();
    step(); set_in(0, 1, 10, 1); #1;
    chk("fl_ctrl", 32'(ifb.ctrl_signal), 32'h00);
    chk("fl_flag", 32'(ifb.flush),       32'h1);
    step(); set_in(0, 1, 3, 0); #1;
    chk("fl_restart", 32'(ifb.ctrl_signal), 32'h0F);
    step();
    step();
    step(); set_in(0, 0, 0, 0); #1;
    chk("fl_done", 32'(ifb.ex_mc_done), 32'h1);
    chk("fl_cnt",  ifb.stall_cycles,    32'd50);

    // longest op, N=63
    step(); set_in(0, 1, 63, 0);
    repeat (62) step();
    step(); set_in(0, 0, 0, 0); #1;
    chk("n63_done", 32'(ifb.ex_mc_done), 32'h1);
    chk("n63_cnt",  ifb.stall_cycles,    32'd113);

    // async reset at T+2 of an N=20 op
    step(); set_in(0, 1, 20, 0);
    step();
    step();
    #1 rst = 1'b0;
    #1;
    chk("ar_ctrl",  32'(ifb.ctrl_signal), 32'h0);
    chk("ar_busy",  32'(ifb.mc_busy),     32'h0);
    chk("ar_cnt",   ifb.stall_cycles,     32'd0);
    set_in(0, 0, 0, 0);
    step();
    step();
    rst = 1'b1;
    repeat (25) step();

    // saturation of the 4-bit counter
    step(); set_in(1, 0, 0, 0);
    repeat (17) step();
    #1;
    chk("sat_s",   32'(ifs.stall_cycles), 32'hF);
    chk("sat_big", ifb.stall_cycles,      32'd17);
    repeat (3) step();
    #1;
    chk("sat_hold", 32'(ifs.stall_cycles), 32'hF);
    set_in(0, 0, 0, 0);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      step();
      set_in($urandom_range(0, 3) == 0,
             $urandom_range(0, 2) == 0,
             ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 6)),
             $urandom_range(0, 24) == 0);
    end
    step(); set_in(0, 0, 0, 0);
    repeat (70) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline control unit for the 5-stage core. It merges stall requests from the ID stage (load-use) and the EX stage (multi-cycle operations such as mult-accumulate and divide). It sequences multi-cycle EX operations with an internal FSM and cycle counter, and drives the 6-bit `ctrl_signal` bus consumed by the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It also handles pipeline flush and keeps a saturating stall-cycle counter.

Parameters:
CNT_W, 6, width of the multi-cycle length field and internal countdown counter.
PERF_W, 32, width of the stall-cycle performance counter.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous reset, active-low.
stallreq_id  input  1  ID stage requests a one-cycle stall (load-use hazard).
ex_mc_start  input  1  EX holds a multi-cycle op; sampled only in IDLE.
ex_mc_cycles  input  CNT_W  total EX occupancy N of the op, in cycles; 0 is treated as 1.
flush_req  input  1  exception/redirect; kills in-flight state.
ctrl_signal  output  6  stall vector: [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB, [5] reserved (always 0).
ex_mc_done  output  1  one-cycle pulse: EX result valid; EX/MEM latches it this cycle.
mc_busy  output  1  FSM is in BUSY state.
flush  output  1  combinational copy of the accepted flush_req.
stall_cycles  output  PERF_W  count of cycles with ctrl_signal[0]=1, saturating.

Behaviour:
- Reset (rst=0, async): state=IDLE, cnt=0, stall_cycles=0. Outputs are ctrl_signal=6'b000000, ex_mc_done=0, mc_busy=0, flush=0.
- Reset asserted mid-operation aborts immediately. No done pulse is produced afterwards.
- FSM states: IDLE, BUSY, DONE.
  - IDLE with ex_mc_start=1 and flush_req=0: let N=max(ex_mc_cycles,1). If N=1, go to DONE. Otherwise go to BUSY with cnt=N-1.
  - BUSY: cnt decrements by 1 each cycle. When cnt==1, the next state is DONE.
  - DONE: ex_mc_done=1; next state is IDLE. ex_mc_start is ignored in DONE and in BUSY.
- Timing: start first seen at cycle T. The EX stall is active in cycles T through T+N-1 (N cycles total). ex_mc_done=1 and the EX stall is released at cycle T+N.
- EX stall is active when (IDLE and ex_mc_start) or BUSY.
- ctrl_signal is combinational from state and inputs. Priority is flush > EX stall > ID stall:
  - flush_req=1: ctrl_signal=000000, flush=1, next state IDLE, cnt=0, no done pulse. This applies in any state, including DONE.
  - EX stall: ctrl_signal=001111. PC, IF/ID and ID/EX hold; EX/MEM receives a bubble.
  - stallreq_id only: ctrl_signal=000111. PC and IF/ID hold; ID/EX receives a bubble.
  - Otherwise: 000000.
- Simultaneous EX stall and stallreq_id gives 001111; the ID request is re-evaluated after the EX stall releases.
- In the DONE cycle with stallreq_id=1, ctrl_signal=000111 and ex_mc_done=1 in the same cycle.
- mc_busy=1 only in BUSY state.
- stall_cycles increments by 1 on each rising edge where ctrl_signal[0]=1. It holds at all ones (no wrap) and is not cleared by flush.
- N=2^CNT_W-1 (63) is legal and gives 63 stall cycles.

Test Plan:
1. Reset then idle: rst low for 3 cycles, then high with all inputs 0 -> ctrl_signal=000000, ex_mc_done=0, stall_cycles=0 throughout.
2. ID load-use: stallreq_id=1 for exactly 1 cycle -> ctrl_signal=000111 in that cycle only; stall_cycles becomes 1.
3. Multi-cycle divide: ex_mc_start=1 with ex_mc_cycles=34 at T, held until done -> ctrl_signal=001111 for T..T+33, mc_busy=1 for T+1..T+33, ex_mc_done pulse at T+34, stall_cycles=34. Repeat with ex_mc_cycles=0 and =1 -> 1 stall cycle at T, done at T+1.
4. Priority overlap: during BUSY, assert stallreq_id -> ctrl_signal stays 001111. Hold stallreq_id into the DONE cycle -> 000111 with ex_mc_done=1.
5. Flush mid-op: start with N=10, assert flush_req at T+4 -> ctrl_signal=000000 and flush=1 at T+4, state IDLE at T+5, no ex_mc_done. A new start at T+5 with N=3 gives done at T+8.
6. Async reset mid-op and saturation: drop rst at T+2 of an N=20 op -> outputs go to 0 immediately with no later done. Preload stall_cycles near all ones (forced), stall 3 cycles -> holds at FFFFFFFF.
